score_keeper: RTL and testbench

- Registered successor to the combinational score-to-display decoder.
- Owns both players' goal counters as two-digit BCD, detects the win condition, and holds a PLAY/OVER game state.
- Drives two-digit active-low 7-segment displays per player; the winner's display blinks once the game is over.
- Sits between the goal sensors/debouncers and the board display pins.

---
 rtl/score_keeper.sv | 186 ++++++++++++++++++
 tb/tb_score_keeper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: two-player goal counter with BCD scores, win detection,
// PLAY/OVER game state and registered active-low 7-segment display drive.
// The winner's display blinks while the game is over.
module score_keeper #(
  parameter int WIN_SCORE    = 5,
  parameter int BLINK_CYCLES = 25000000,
  parameter int LEAD_BLANK   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        goal1,
  input  logic        goal2,
  input  logic        new_game,
  output logic [13:0] seg1,
  output logic [13:0] seg2,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        bar
);

  // Winning score as a BCD pair {tens, units}.
  localparam logic [3:0] WIN_TENS  = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_UNITS = 4'(WIN_SCORE % 10);
  localparam logic [7:0] WIN_BCD   = {WIN_TENS, WIN_UNITS};

  localparam int              CNT_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] TENS_RST  = (LEAD_BLANK != 0) ? SEG_BLANK : SEG_ZERO;

  typedef enum logic {PLAY, OVER} state_t;

  state_t           state_q;
  logic             goal1_prev_q, goal2_prev_q;
  logic [7:0]       score1_q, score2_q;
  logic [7:0]       score1_d, score2_d;
  logic [1:0]       winner_q;
  logic             game_over_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_on_q;
  logic [13:0]      seg1_q, seg2_q;
  logic [13:0]      seg1_d, seg2_d;
  logic             rise1, rise2;
  logic             win1, win2;

  // BCD increment of a {tens, units} pair.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s[3:0] == 4'd9) begin
      bcd_inc = {s[7:4] + 4'd1, 4'd0};
    end else begin
      bcd_inc = {s[7:4], s[3:0] + 4'd1};
    end
  endfunction

  // Active-low gfedcba code for one decimal digit; anything else is blank.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  // Two-digit display word, with optional leading-zero suppression.
  function automatic logic [13:0] score_disp(input logic [7:0] s);
    logic [6:0] tens;
    if ((LEAD_BLANK != 0) && (s[7:4] == 4'd0)) begin
      tens = SEG_BLANK;
    end else begin
      tens = digit_seg(s[7:4]);
    end
    score_disp = {tens, digit_seg(s[3:0])};
  endfunction

  // Goal edge detection and saturating candidate scores for this cycle.
  always_comb begin
    rise1    = goal1 & ~goal1_prev_q;
    rise2    = goal2 & ~goal2_prev_q;
    score1_d = score1_q;
    score2_d = score2_q;
    if (rise1 && (score1_q != WIN_BCD)) begin
      score1_d = bcd_inc(score1_q);
    end
    if (rise2 && (score2_q != WIN_BCD)) begin
      score2_d = bcd_inc(score2_q);
    end
    win1 = (score1_d == WIN_BCD);
    win2 = (score2_d == WIN_BCD);
  end

  // Game FSM: scores, state, winner and game_over all move on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PLAY;
      goal1_prev_q <= 1'b0;
      goal2_prev_q <= 1'b0;
      score1_q     <= 8'h00;
      score2_q     <= 8'h00;
      winner_q     <= 2'b00;
      game_over_q  <= 1'b0;
    end else begin
      goal1_prev_q <= goal1;
      goal2_prev_q <= goal2;
      if (new_game) begin
        // Goal rises coinciding with new_game are deliberately dropped.
        state_q     <= PLAY;
        score1_q    <= 8'h00;
        score2_q    <= 8'h00;
        winner_q    <= 2'b00;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          PLAY: begin
            score1_q <= score1_d;
            score2_q <= score2_d;
            if (win1 || win2) begin
              state_q     <= OVER;
              winner_q    <= {win2, win1};
              game_over_q <= 1'b1;
            end
          end
          OVER: begin
            // Scores frozen until new_game or reset.
          end
          default: state_q <= PLAY;
        endcase
      end
    end
  end

  // Blink timebase: only runs in OVER, restarts in the on phase otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (new_game || (state_q != OVER)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Display words from the current registered state; winner blanks when off.
  always_comb begin
    seg1_d = score_disp(score1_q);
    seg2_d = score_disp(score2_q);
    if (game_over_q && !blink_on_q && winner_q[0]) begin
      seg1_d = {SEG_BLANK, SEG_BLANK};
    end
    if (game_over_q && !blink_on_q && winner_q[1]) begin
      seg2_d = {SEG_BLANK, SEG_BLANK};
    end
  end

  // Display output registers, one cycle behind the game state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg1_q <= {TENS_RST, SEG_ZERO};
      seg2_q <= {TENS_RST, SEG_ZERO};
    end else begin
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
    end
  end

  assign seg1      = seg1_q;
  assign seg2      = seg2_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;
  assign bar       = 1'b0;

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper: three instances with different
// parameter sets share clock and reset; each gets its own goal/new_game.
module tb_score_keeper;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  g1, g2, ng;
  logic [13:0] s1 [3];
  logic [13:0] s2 [3];
  logic [1:0]  win [3];
  logic        go [3];
  logic        bar_w [3];

  int checks;
  int failures;

  // Instance 0: win at 5, short blink, leading blank.
  score_keeper #(.WIN_SCORE(5), .BLINK_CYCLES(3), .LEAD_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .goal1(g1[0]), .goal2(g2[0]), .new_game(ng[0]),
    .seg1(s1[0]), .seg2(s2[0]), .winner(win[0]), .game_over(go[0]), .bar(bar_w[0])
  );

  // Instance 1: win at 12, blink half-period of 4.
  score_keeper #(.WIN_SCORE(12), .BLINK_CYCLES(4), .LEAD_BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .goal1(g1[1]), .goal2(g2[1]), .new_game(ng[1]),
    .seg1(s1[1]), .seg2(s2[1]), .winner(win[1]), .game_over(go[1]), .bar(bar_w[1])
  );

  // Instance 2: win at 20, tens zero shown.
  score_keeper #(.WIN_SCORE(20), .BLINK_CYCLES(2), .LEAD_BLANK(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .goal1(g1[2]), .goal2(g2[2]), .new_game(ng[2]),
    .seg1(s1[2]), .seg2(s2[2]), .winner(win[2]), .game_over(go[2]), .bar(bar_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1(input int k);
    g1[k] = 1'b1;
    tick();
    g1[k] = 1'b0;
    tick();
  endtask

  task automatic pulse2(input int k);
    g2[k] = 1'b1;
    tick();
    g2[k] = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    g1 = '0;
    g2 = '0;
    ng = '0;
    g2[2] = 1'b1;  // held high through reset: must count exactly once
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_a_seg1", 32'(s1[0]), 32'({BL, D0}));
    check("rst_c_seg2_noblank", 32'(s2[2]), 32'({D0, D0}));
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_a_seg1", 32'(s1[0]), 32'({BL, D0}));
    check("idle_a_seg2", 32'(s2[0]), 32'({BL, D0}));
    check("idle_a_winner", 32'(win[0]), 32'd0);
    check("idle_a_over", 32'(go[0]), 32'd0);
    check("idle_a_bar", 32'(bar_w[0]), 32'd0);
    check("idle_b_seg2", 32'(s2[1]), 32'({BL, D0}));
    check("c_held_from_reset", 32'(s2[2]), 32'({D0, D1}));

    // Instance A: three goals for player 1, with latency check on the third.
    pulse1(0);
    pulse1(0);
    g1[0] = 1'b1;
    tick();
    check("a_lat_1cyc", 32'(s1[0]), 32'({BL, D2}));
    tick();
    check("a_lat_2cyc", 32'(s1[0]), 32'({BL, D3}));
    check("a_seg2_steady", 32'(s2[0]), 32'({BL, D0}));
    g1[0] = 1'b0;
    tick();
    g1[0] = 1'b1;
    repeat (20) tick();
    g1[0] = 1'b0;
    tick();
    tick();
    check("a_hold_once", 32'(s1[0]), 32'({BL, D4}));
    repeat (4) pulse2(0);
    check("a_p2_four", 32'(s2[0]), 32'({BL, D4}));

    // Simultaneous rise at 4-4 gives a draw on that same edge.
    g1[0] = 1'b1;
    g2[0] = 1'b1;
    tick();
    check("a_draw_winner", 32'(win[0]), 32'd3);
    check("a_draw_over", 32'(go[0]), 32'd1);
    g1[0] = 1'b0;
    g2[0] = 1'b0;
    tick();
    check("a_draw_seg1_on", 32'(s1[0]), 32'({BL, D5}));
    check("a_draw_seg2_on", 32'(s2[0]), 32'({BL, D5}));
    repeat (3) tick();
    check("a_draw_seg1_off", 32'(s1[0]), 32'({BL, BL}));
    check("a_draw_seg2_off", 32'(s2[0]), 32'({BL, BL}));
    g1[0] = 1'b1;
    g2[0] = 1'b1;
    tick();
    g1[0] = 1'b0;
    g2[0] = 1'b0;
    tick();
    tick();
    check("a_frozen_seg1", 32'(s1[0]), 32'({BL, D5}));
    check("a_frozen_seg2", 32'(s2[0]), 32'({BL, D5}));
    check("a_frozen_winner", 32'(win[0]), 32'd3);

    // new_game in OVER together with a goal rise.
    ng[0] = 1'b1;
    g1[0] = 1'b1;
    tick();
    check("a_ng_over", 32'(go[0]), 32'd0);
    check("a_ng_winner", 32'(win[0]), 32'd0);
    ng[0] = 1'b0;
    tick();
    check("a_ng_seg1_discard", 32'(s1[0]), 32'({BL, D0}));
    check("a_ng_seg2", 32'(s2[0]), 32'({BL, D0}));
    g1[0] = 1'b0;

    // Instance C: tens zero visible, then BCD carry 9 -> 10.
    repeat (7) pulse1(2);
    check("c_seven", 32'(s1[2]), 32'({D0, D7}));
    repeat (2) pulse1(2);
    check("c_nine", 32'(s1[2]), 32'({D0, D9}));
    pulse1(2);
    check("c_ten", 32'(s1[2]), 32'({D1, D0}));
    check("c_no_winner", 32'(win[2]), 32'd0);

    // Instance B: player 2 reaches 12, then blink timing.
    repeat (11) pulse2(1);
    check("b_eleven", 32'(s2[1]), 32'({D1, D1}));
    check("b_not_over", 32'(go[1]), 32'd0);
    g2[1] = 1'b1;
    tick();
    check("b_winner", 32'(win[1]), 32'd2);
    check("b_over", 32'(go[1]), 32'd1);
    g2[1] = 1'b0;
    tick();
    check("b_seg2_on_first", 32'(s2[1]), 32'({D1, D2}));
    check("b_seg1_steady0", 32'(s1[1]), 32'({BL, D0}));
    repeat (3) tick();
    check("b_seg2_on_last", 32'(s2[1]), 32'({D1, D2}));
    tick();
    check("b_seg2_off_first", 32'(s2[1]), 32'({BL, BL}));
    check("b_seg1_steady1", 32'(s1[1]), 32'({BL, D0}));
    repeat (3) tick();
    check("b_seg2_off_last", 32'(s2[1]), 32'({BL, BL}));
    tick();
    check("b_seg2_on_again", 32'(s2[1]), 32'({D1, D2}));
    repeat (5) tick();
    check("b_seg2_off_again", 32'(s2[1]), 32'({BL, BL}));

    // Reset in the middle of the blank phase.
    rst_n = 1'b0;
    tick();
    check("b_rst_seg2", 32'(s2[1]), 32'({BL, D0}));
    check("b_rst_seg1", 32'(s1[1]), 32'({BL, D0}));
    check("b_rst_winner", 32'(win[1]), 32'd0);
    check("b_rst_over", 32'(go[1]), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
